// File: rtl/lsu_queue_if.sv
// lsu_queue_if: core request/response and data-memory bundle for lsu_queue.
// slave = queue side, master = core plus data-memory side.
interface lsu_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) ();

  // core request
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_wen_i;
  logic              req_byte_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic [RD_W-1:0]   req_rd_i;

  // data-memory request
  logic              mem_valid_o;
  logic              mem_wen_o;
  logic              mem_byte_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_yumi_i;

  // data-memory response
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_yumi_o;

  // core response
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [DATA_W-1:0] resp_data_o;
  logic [RD_W-1:0]   resp_rd_o;
  logic              resp_is_load_o;

  modport slave (
    input  req_valid_i, req_wen_i, req_byte_i,
    input  req_addr_i, req_wdata_i, req_rd_i,
    output req_ready_o,
    output mem_valid_o, mem_wen_o, mem_byte_o,
    output mem_addr_o, mem_wdata_o,
    input  mem_yumi_i,
    input  mem_rvalid_i, mem_rdata_i,
    output mem_yumi_o,
    output resp_valid_o, resp_data_o,
    output resp_rd_o, resp_is_load_o,
    input  resp_ready_i
  );

  modport master (
    output req_valid_i, req_wen_i, req_byte_i,
    output req_addr_i, req_wdata_i, req_rd_i,
    input  req_ready_o,
    input  mem_valid_o, mem_wen_o, mem_byte_o,
    input  mem_addr_o, mem_wdata_o,
    output mem_yumi_i,
    output mem_rvalid_i, mem_rdata_i,
    input  mem_yumi_o,
    input  resp_valid_o, resp_data_o,
    input  resp_rd_o, resp_is_load_o,
    output resp_ready_i
  );

endinterface

// File: rtl/lsu_queue.sv
// lsu_queue: in-order load/store queue between core and data memory.
// Ports: clk, reset (sync, active-high), bus (lsu_queue_if.slave),
//   count_o occupied entries, idle_o empty, err_o sticky stray response.
module lsu_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int RD_W   = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  lsu_queue_if.slave             bus,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   idle_o,
  output logic                   err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NB = DATA_W / 8;
  localparam int BW = $clog2(NB);

  typedef enum logic [1:0] {
    FREE       = 2'd0,
    WAIT_ISSUE = 2'd1,
    WAIT_RESP  = 2'd2
  } slot_e;

  typedef struct packed {
    logic              wen;
    logic              sz_byte;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [RD_W-1:0]   rd;
  } entry_t;

  entry_t          q  [DEPTH];
  slot_e           st [DEPTH];
  logic [PW-1:0]   alloc_ptr;
  logic [PW-1:0]   issue_ptr;
  logic [PW-1:0]   retire_ptr;
  logic [CW-1:0]   count;
  logic            err;

  logic            ready;
  logic            alloc_fire;
  logic            mem_valid;
  logic            issue_fire;
  logic            ret_wait;
  logic            resp_valid;
  logic            ret_fire;
  logic            bad_rsp;
  logic [7:0]      byte_v;
  logic [DATA_W-1:0] rdata;
  entry_t          new_ent;

  // no bypass: a full queue refuses even when a retire is in flight
  assign ready      = (count < CW'(DEPTH));
  assign alloc_fire = bus.req_valid_i & ready;

  assign mem_valid  = (st[issue_ptr] == WAIT_ISSUE);
  assign issue_fire = mem_valid & bus.mem_yumi_i;

  // responses arrive in order, so they always belong to retire_ptr
  assign ret_wait   = (st[retire_ptr] == WAIT_RESP);
  assign resp_valid = bus.mem_rvalid_i & ret_wait;
  assign ret_fire   = resp_valid & bus.resp_ready_i;
  assign bad_rsp    = bus.mem_rvalid_i & ~ret_wait;

  assign new_ent.wen     = bus.req_wen_i;
  assign new_ent.sz_byte = bus.req_byte_i;
  assign new_ent.addr    = bus.req_addr_i;
  assign new_ent.wdata   = bus.req_wdata_i;
  assign new_ent.rd      = bus.req_rd_i;

  // little-endian byte lane pick for byte loads
  always_comb begin
    byte_v = '0;
    for (int i = 0; i < NB; i++) begin
      if (q[retire_ptr].addr[BW-1:0] == BW'(i))
        byte_v = bus.mem_rdata_i[8*i +: 8];
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (~q[retire_ptr].wen &  q[retire_ptr].sz_byte):
        rdata = DATA_W'(byte_v);
      (~q[retire_ptr].wen & ~q[retire_ptr].sz_byte):
        rdata = bus.mem_rdata_i;
      default:
        rdata = '0;
    endcase
  end

  assign bus.req_ready_o    = ready;
  assign bus.mem_valid_o    = mem_valid;
  assign bus.mem_wen_o      = q[issue_ptr].wen;
  assign bus.mem_byte_o     = q[issue_ptr].sz_byte;
  assign bus.mem_addr_o     = q[issue_ptr].addr;
  assign bus.mem_wdata_o    = q[issue_ptr].wdata;
  assign bus.mem_yumi_o     = ret_fire;
  assign bus.resp_valid_o   = resp_valid;
  assign bus.resp_data_o    = rdata;
  assign bus.resp_rd_o      = q[retire_ptr].rd;
  assign bus.resp_is_load_o = ~q[retire_ptr].wen;

  assign count_o = count;
  assign idle_o  = (count == '0);
  assign err_o   = err;

  // payload needs no reset; slot state gates every use of it
  always_ff @(posedge clk) begin
    if (alloc_fire)
      q[alloc_ptr] <= new_ent;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_ptr  <= '0;
      issue_ptr  <= '0;
      retire_ptr <= '0;
      count      <= '0;
      err        <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        st[i] <= FREE;
    end else begin
      if (alloc_fire) begin
        st[alloc_ptr] <= WAIT_ISSUE;
        alloc_ptr     <= alloc_ptr + PW'(1);
      end
      if (issue_fire) begin
        st[issue_ptr] <= WAIT_RESP;
        issue_ptr     <= issue_ptr + PW'(1);
      end
      if (ret_fire) begin
        st[retire_ptr] <= FREE;
        retire_ptr     <= retire_ptr + PW'(1);
      end
      case ({alloc_fire, ret_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bad_rsp)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lsu_queue.sv
// tb_lsu_queue: directed scoreboard bench for lsu_queue.
// Drives core and memory sides through lsu_queue_if.
module tb_lsu_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;
  localparam int RD_W   = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] count_o;
  logic       idle_o;
  logic       err_o;

  lsu_queue_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_W(RD_W)
  ) bus ();

  lsu_queue #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .DEPTH(DEPTH), .RD_W(RD_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .count_o(count_o),
    .idle_o(idle_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        is_load;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] mem_word [64];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(logic wen, logic byt, logic [31:0] addr,
                         logic [31:0] wdata, logic [4:0] rd);
    bus.req_valid_i = 1'b1;
    bus.req_wen_i   = wen;
    bus.req_byte_i  = byt;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    bus.req_rd_i    = rd;
  endtask

  task automatic push_exp(logic wen, logic byt, logic [31:0] addr,
                          logic [4:0] rd);
    exp_t e;
    logic [31:0] w;
    w = mem_word[addr[7:2]];
    e.rd = rd;
    e.is_load = !wen;
    if (wen)
      e.data = 32'h0;
    else if (byt)
      e.data = {24'h0, w[8*addr[1:0] +: 8]};
    else
      e.data = w;
    exp_q.push_back(e);
    addr_q.push_back(addr);
  endtask

  task automatic rsp_on();
    bus.mem_rvalid_i = 1'b1;
    if (addr_q.size() != 0)
      bus.mem_rdata_i = mem_word[addr_q[0][7:2]];
    else
      bus.mem_rdata_i = $urandom;
  endtask

  task automatic rsp_off();
    bus.mem_rvalid_i = 1'b0;
  endtask

  task automatic check_resp(string tag);
    exp_t e;
    chk({tag, "_rvalid"}, bus.resp_valid_o, 1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb got empty queue exp entry", tag);
    end else begin
      e = exp_q.pop_front();
      void'(addr_q.pop_front());
      chk({tag, "_data"}, bus.resp_data_o, e.data);
      chk({tag, "_rd"}, bus.resp_rd_o, e.rd);
      chk({tag, "_isld"}, bus.resp_is_load_o, e.is_load);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.req_wen_i    = 1'b0;
    bus.req_byte_i   = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_wdata_i  = '0;
    bus.req_rd_i     = '0;
    bus.mem_yumi_i   = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.resp_ready_i = 1'b1;
    for (int i = 0; i < 64; i++)
      mem_word[i] = 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
    mem_word[4] = 32'hDEADBEEF;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("rst_ready", bus.req_ready_o, 1);
    chk("rst_mvalid", bus.mem_valid_o, 0);
    chk("rst_rvalid", bus.resp_valid_o, 0);
    chk("rst_myumi", bus.mem_yumi_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_err", err_o, 0);

    // single word load
    set_req(0, 0, 32'h10, 32'h0, 5'd3);
    push_exp(0, 0, 32'h10, 5'd3);
    #1 chk("t1_ready", bus.req_ready_o, 1);
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    chk("t1_count", count_o, 1);
    chk("t1_mvalid", bus.mem_valid_o, 1);
    chk("t1_maddr", bus.mem_addr_o, 32'h10);
    chk("t1_mwen", bus.mem_wen_o, 0);
    bus.mem_yumi_i = 1'b1;
    tick();
    bus.mem_yumi_i = 1'b0;
    #1 chk("t1_mvalid_off", bus.mem_valid_o, 0);
    tick();
    rsp_on();
    #1;
    chk("t1_myumi", bus.mem_yumi_o, 1);
    check_resp("t1");
    tick();
    rsp_off();
    #1;
    chk("t1_idle", idle_o, 1);
    chk("t1_count0", count_o, 0);

    // byte load from lane 3
    mem_word[4] = 32'hAABBCCDD;
    set_req(0, 1, 32'h13, 32'h0, 5'd4);
    push_exp(0, 1, 32'h13, 5'd4);
    tick();
    bus.req_valid_i = 1'b0;
    #1 chk("t2_mbyte", bus.mem_byte_o, 1);
    bus.mem_yumi_i = 1'b1;
    tick();
    bus.mem_yumi_i = 1'b0;
    rsp_on();
    #1 check_resp("t2");
    chk("t2_lit", bus.resp_data_o, 32'h0000_00AA);
    tick();
    rsp_off();

    // word store
    set_req(1, 0, 32'h08, 32'h1234_5678, 5'd7);
    push_exp(1, 0, 32'h08, 5'd7);
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    chk("ts_mwen", bus.mem_wen_o, 1);
    chk("ts_mwdata", bus.mem_wdata_o, 32'h1234_5678);
    bus.mem_yumi_i = 1'b1;
    tick();
    bus.mem_yumi_i = 1'b0;
    rsp_on();
    #1 check_resp("ts");
    tick();
    rsp_off();

    // fill to DEPTH with memory stalled
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_req(0, 0, 32'h20 + 32'(4 * k), 32'h0, 5'(10 + k));
      #1 chk("t3_ready", bus.req_ready_o, (k < 4) ? 1 : 0);
      if (k < 4)
        push_exp(0, 0, 32'h20 + 32'(4 * k), 5'(10 + k));
      tick();
    end
    bus.req_valid_i = 1'b0;
    #1;
    chk("t3_count", count_o, 4);
    chk("t3_ready_lo", bus.req_ready_o, 0);
    chk("t3_maddr", bus.mem_addr_o, 32'h20);
    tick();
    chk("t3_maddr_hold", bus.mem_addr_o, 32'h20);
    chk("t3_mvalid_hold", bus.mem_valid_o, 1);
    chk("t3_count_hold", count_o, 4);

    // issue all four in order
    bus.mem_yumi_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t4_iaddr", bus.mem_addr_o, 32'h20 + 32'(4 * k));
      chk("t4_ivalid", bus.mem_valid_o, 1);
      tick();
    end
    bus.mem_yumi_i = 1'b0;
    #1 chk("t4_all_issued", bus.mem_valid_o, 0);

    // full: retire and request same cycle -> refused
    set_req(0, 0, 32'h40, 32'h0, 5'd9);
    rsp_on();
    #1;
    chk("t4_full_ready", bus.req_ready_o, 0);
    check_resp("t4a");
    tick();
    rsp_off();
    push_exp(0, 0, 32'h40, 5'd9);
    #1 chk("t4_ready_next", bus.req_ready_o, 1);
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    chk("t4_count4", count_o, 4);
    chk("t4_wrap_mvalid", bus.mem_valid_o, 1);
    chk("t4_wrap_maddr", bus.mem_addr_o, 32'h40);

    // issue wrapped slot 0 while retiring entry 1
    bus.mem_yumi_i = 1'b1;
    rsp_on();
    #1 check_resp("t4c");
    tick();
    bus.mem_yumi_i = 1'b0;

    // simultaneous alloc and retire
    set_req(1, 0, 32'h44, 32'hCAFE_F00D, 5'd12);
    push_exp(1, 0, 32'h44, 5'd12);
    rsp_on();
    #1;
    chk("t4d_ready", bus.req_ready_o, 1);
    chk("t4d_count", count_o, 3);
    check_resp("t4d");
    tick();
    bus.req_valid_i = 1'b0;
    #1 chk("t4d_count_same", count_o, 3);

    bus.mem_yumi_i = 1'b1;
    rsp_on();
    #1;
    chk("t4e_maddr", bus.mem_addr_o, 32'h44);
    chk("t4e_mwen", bus.mem_wen_o, 1);
    check_resp("t4e");
    tick();
    bus.mem_yumi_i = 1'b0;
    rsp_on();
    #1 check_resp("t4f");
    tick();
    rsp_on();
    #1 check_resp("t4g");
    tick();
    rsp_off();
    #1;
    chk("t4_idle", idle_o, 1);
    chk("t4_sb_empty", exp_q.size(), 0);

    // core back-pressure on response
    set_req(0, 0, 32'h0C, 32'h0, 5'd5);
    push_exp(0, 0, 32'h0C, 5'd5);
    tick();
    bus.req_valid_i = 1'b0;
    bus.mem_yumi_i = 1'b1;
    tick();
    bus.mem_yumi_i = 1'b0;
    bus.resp_ready_i = 1'b0;
    rsp_on();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_rvalid", bus.resp_valid_o, 1);
      chk("t5_myumi_lo", bus.mem_yumi_o, 0);
      chk("t5_count", count_o, 1);
      tick();
    end
    bus.resp_ready_i = 1'b1;
    #1;
    chk("t5_myumi", bus.mem_yumi_o, 1);
    check_resp("t5");
    tick();
    rsp_off();
    #1 chk("t5_count0", count_o, 0);

    // reset mid-flight, then a stray response
    set_req(0, 0, 32'h14, 32'h0, 5'd6);
    tick();
    bus.req_valid_i = 1'b0;
    bus.mem_yumi_i = 1'b1;
    tick();
    bus.mem_yumi_i = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t6_count", count_o, 0);
    chk("t6_mvalid", bus.mem_valid_o, 0);
    chk("t6_err0", err_o, 0);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i = 32'h1111_2222;
    #1;
    chk("t6_rvalid", bus.resp_valid_o, 0);
    chk("t6_myumi", bus.mem_yumi_o, 0);
    tick();
    rsp_off();
    #1 chk("t6_err", err_o, 1);
    tick();
    tick();
    chk("t6_err_sticky", err_o, 1);
    chk("t6_idle", idle_o, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 chk("t6_err_clr", err_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_queue.md
LSU_QUEUE -- requirements
Module: lsu_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 32, data memory byte-address width.
REQ-003 SHALL have parameter DEPTH, default 4, max outstanding requests; power of two, >=2.
REQ-004 SHALL have parameter RD_W, default 5, destination-register tag width.
REQ-005 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have ports req_valid_i/req_ready_o  in/out  1  core request handshake; transfer when both high.
REQ-008 SHALL have ports req_wen_i, req_byte_i  input  1  store select; byte (1) or word (0) access.
REQ-009 SHALL have ports req_addr_i  input  ADDR_W and req_wdata_i  input  DATA_W  address and store data.
REQ-010 SHALL have port req_rd_i  input  RD_W  load destination tag.
REQ-011 SHALL have ports mem_valid_o, mem_wen_o, mem_byte_o  output  1  request to data memory.
REQ-012 SHALL have ports mem_addr_o  output  ADDR_W and mem_wdata_o  output  DATA_W.
REQ-013 SHALL have port mem_yumi_i  input  1  memory accepted current request.
REQ-014 SHALL have ports mem_rvalid_i  input  1, mem_rdata_i  input  DATA_W  memory response.
REQ-015 SHALL have port mem_yumi_o  output  1  response consumed.
REQ-016 SHALL have ports resp_valid_o  output  1, resp_ready_i  input  1  response handshake to core.
REQ-017 SHALL have ports resp_data_o  output  DATA_W, resp_rd_o  output  RD_W, resp_is_load_o  output  1.
REQ-018 SHALL have ports count_o  output  $clog2(DEPTH)+1, idle_o  output  1, err_o  output  1.

Function
REQ-019 SHALL hold a circular queue of DEPTH entries {wen, byte, addr, wdata, rd}; each entry FREE, WAIT_ISSUE or WAIT_RESP.
REQ-020 SHALL keep three pointers: alloc, issue, retire, each wrapping DEPTH-1 -> 0.
REQ-021 SHALL drive req_ready_o = (count < DEPTH); no same-cycle bypass of retire into a full queue.
REQ-022 SHALL, on request transfer, write entry at alloc as WAIT_ISSUE, advance alloc, count+1.
REQ-023 SHALL drive mem_valid_o high while entry at issue is WAIT_ISSUE; mem_* fields from that entry, held stable until mem_yumi_i.
REQ-024 SHALL, on mem_valid_o & mem_yumi_i, mark entry WAIT_RESP and advance issue; at most one issue per cycle.
REQ-025 SHALL return responses strictly in order; mem_rvalid_i always belongs to entry at retire.
REQ-026 SHALL drive resp_valid_o = mem_rvalid_i & (retire entry is WAIT_RESP); combinational, zero added latency.
REQ-027 SHALL drive mem_yumi_o = resp_valid_o & resp_ready_i; on that cycle free retire entry, advance retire, count-1.
REQ-028 SHALL give resp_data_o = mem_rdata_i for word loads; byte loads zero-extend byte addr[1:0] (little-endian, byte 0 = bits 7:0).
REQ-029 SHALL give resp_data_o = 0 and resp_is_load_o = 0 for stores; resp_rd_o = stored tag.
REQ-030 SHALL, on simultaneous alloc and retire, leave count unchanged; simultaneous alloc/issue/retire all legal.
REQ-031 SHALL set err_o sticky when mem_rvalid_i is high and retire entry is not WAIT_RESP; response then ignored, mem_yumi_o 0.
REQ-032 SHALL drive idle_o = (count == 0); count_o = occupied entries (0..DEPTH).
REQ-033 SHALL ignore req_valid_i while req_ready_o is low; no state change.

Reset
REQ-034 SHALL, with reset high at clk edge, clear pointers, count, err_o and mark all entries FREE.
REQ-035 SHALL hold mem_valid_o, resp_valid_o, mem_yumi_o low and req_ready_o high from the cycle after reset.
REQ-036 SHALL, on reset mid-operation, discard all outstanding entries; later mem responses set err_o.

Verification
REQ-037 Single word load addr 0x10, tag 3, mem_yumi_i cycle 1, rvalid cycle 3 data 0xDEADBEEF -> resp 0xDEADBEEF, rd 3, is_load 1, idle_o returns 1.
REQ-038 Byte load addr 0x13, rdata 0xAABBCCDD -> resp_data 0x000000AA.
REQ-039 DEPTH=4, five back-to-back requests, mem_yumi_i low -> req_ready_o low after 4th, count_o 4, mem_valid_o steady on entry 0.
REQ-040 Full queue, retire and new request same cycle -> request refused that cycle, accepted next, count stays 4, pointers wrap to 0.
REQ-041 resp_ready_i low for 3 cycles with rvalid held -> mem_yumi_o low, no retire; then high -> single retire.
REQ-042 mem_rvalid_i while idle -> err_o 1 next cycle and stays until reset.
